// File: rtl/timing_nco.sv
// rtl/timing_nco.sv - symbol-timing NCO: modulo-1 decrementing accumulator, strobe + mu, ACQ/TRACK FSM
// Optional build macro TIMING_NCO_SLIP_CNT_EN enables the TRACK-state timing-slip counter.
module timing_nco #(
    parameter int WERR       = 18,
    parameter int NCO_W      = 24,
    parameter int LOG2_SPS   = 2,
    parameter int CTRL_SHIFT = 4,
    parameter int MU_W       = 16,
    parameter int ACQ_SYMS   = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable_i,
    input  logic                   din_valid_i,
    input  logic signed [WERR-1:0] ctrl_i,
    input  logic                   ctrl_val_i,
    output logic                   strobe_o,
    output logic [MU_W-1:0]        mu_o,
    output logic                   sat_o,
    output logic [1:0]             state_o,
    output logic [15:0]            slip_cnt_o
);

    localparam int SW = NCO_W + 2;
    localparam int AW = $clog2(ACQ_SYMS + 1);

    localparam logic [NCO_W-1:0] W_NOM_U    = NCO_W'(1) << (NCO_W - LOG2_SPS);
    localparam logic [NCO_W-1:0] STEP_MAX_U = W_NOM_U + (W_NOM_U >> 3);
    localparam logic [NCO_W-1:0] STEP_MIN_U = W_NOM_U - (W_NOM_U >> 3);

    localparam logic signed [SW-1:0] W_NOM    = signed'({2'b00, W_NOM_U});
    localparam logic signed [SW-1:0] STEP_MAX = signed'({2'b00, STEP_MAX_U});
    localparam logic signed [SW-1:0] STEP_MIN = signed'({2'b00, STEP_MIN_U});

    localparam logic [AW-1:0] ACQ_LAST = AW'(ACQ_SYMS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACQ   = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic signed [WERR-1:0] ctrl_reg;
    logic [NCO_W-1:0]       acc;
    logic [AW-1:0]          acq_cnt;

    logic signed [SW-1:0]   ctrl_sh;
    logic signed [SW-1:0]   step_raw;
    logic [NCO_W-1:0]       step;
    logic                   clamp;
    logic                   wrap;
    logic [NCO_W-1:0]       acc_dec;
    logic                   run;

    // Loop correction only steers the NCO once the loop has settled (TRACK).
    assign ctrl_sh  = {{(SW-WERR-CTRL_SHIFT){ctrl_reg[WERR-1]}}, ctrl_reg, {CTRL_SHIFT{1'b0}}};
    assign step_raw = W_NOM + ((state == S_TRACK) ? ctrl_sh : '0);

    always_comb begin
        step  = step_raw[NCO_W-1:0];
        clamp = 1'b0;
        if (step_raw > STEP_MAX) begin
            step  = STEP_MAX_U;
            clamp = 1'b1;
        end else if (step_raw < STEP_MIN) begin
            step  = STEP_MIN_U;
            clamp = 1'b1;
        end
    end

    assign wrap    = (acc < step);
    assign acc_dec = acc - step;

    always_comb begin
        state_next = state;
        run        = 1'b0;
        if (!enable_i) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_next = S_ACQ;
                S_ACQ: begin
                    run = din_valid_i;
                    if (din_valid_i && wrap && (acq_cnt == ACQ_LAST))
                        state_next = S_TRACK;
                end
                S_TRACK: run = din_valid_i;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ctrl_reg <= '0;
        else if (ctrl_val_i)
            ctrl_reg <= ctrl_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            acq_cnt  <= '0;
            strobe_o <= 1'b0;
            mu_o     <= '0;
            sat_o    <= 1'b0;
        end else if (!enable_i || (state == S_IDLE)) begin
            acc      <= '0;
            acq_cnt  <= '0;
            strobe_o <= 1'b0;
            mu_o     <= '0;
            sat_o    <= 1'b0;
        end else if (run) begin
            acc      <= acc_dec;
            sat_o    <= clamp;
            strobe_o <= wrap;
            if (wrap) begin
                // mu is the pre-decrement residue scaled by samples-per-symbol.
                mu_o <= acc[NCO_W-1-LOG2_SPS -: MU_W];
                if (state == S_ACQ)
                    acq_cnt <= acq_cnt + 1'b1;
            end
        end else begin
            strobe_o <= 1'b0;
        end
    end

`ifdef TIMING_NCO_SLIP_CNT_EN
    localparam logic [15:0] GAP_M1 = 16'((1 << LOG2_SPS) - 1);

    logic [15:0] samp_cnt;
    logic [15:0] slip_cnt;

    // samp_cnt holds the number of non-strobe valid samples since the last strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp_cnt <= '0;
            slip_cnt <= '0;
        end else if (!enable_i || (state == S_IDLE)) begin
            samp_cnt <= '0;
        end else if (run) begin
            if (wrap) begin
                samp_cnt <= '0;
                if ((state == S_TRACK) && (samp_cnt != GAP_M1) && (slip_cnt != 16'hFFFF))
                    slip_cnt <= slip_cnt + 16'd1;
            end else if (samp_cnt != 16'hFFFF) begin
                samp_cnt <= samp_cnt + 16'd1;
            end
        end
    end

    assign slip_cnt_o = slip_cnt;
`else
    assign slip_cnt_o = '0;
`endif

    assign state_o = state;

endmodule

// File: tb/tb_timing_nco.sv
// tb/tb_timing_nco.sv - scoreboard bench for timing_nco against an arithmetic reference model
module tb_timing_nco;

    localparam int WERR       = 18;
    localparam int NCO_W      = 24;
    localparam int LOG2_SPS   = 2;
    localparam int CTRL_SHIFT = 4;
    localparam int MU_W       = 16;
    localparam int ACQ_SYMS   = 16;

    localparam longint MODV  = 64'd1 << NCO_W;
    localparam longint W_NOM = 64'd1 << (NCO_W - LOG2_SPS);
    localparam longint SMIN  = W_NOM - W_NOM / 8;
    localparam longint SMAX  = W_NOM + W_NOM / 8;
    localparam int     SPS   = 1 << LOG2_SPS;

    logic                   clk         = 1'b0;
    logic                   reset_n     = 1'b0;
    logic                   enable_i    = 1'b0;
    logic                   din_valid_i = 1'b0;
    logic                   ctrl_val_i  = 1'b0;
    logic signed [WERR-1:0] ctrl_i      = '0;
    logic                   strobe_o;
    logic [MU_W-1:0]        mu_o;
    logic                   sat_o;
    logic [1:0]             state_o;
    logic [15:0]            slip_cnt_o;

    timing_nco #(
        .WERR(WERR), .NCO_W(NCO_W), .LOG2_SPS(LOG2_SPS),
        .CTRL_SHIFT(CTRL_SHIFT), .MU_W(MU_W), .ACQ_SYMS(ACQ_SYMS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .din_valid_i(din_valid_i),
        .ctrl_i(ctrl_i), .ctrl_val_i(ctrl_val_i), .strobe_o(strobe_o), .mu_o(mu_o),
        .sat_o(sat_o), .state_o(state_o), .slip_cnt_o(slip_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int strobe;
        int mu;
        int sat;
        int state;
        int slip;
    } exp_t;

    exp_t exq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    longint m_acc, m_ctrl;
    int     m_state, m_acq, m_strobe, m_mu, m_sat, m_slip, m_gap;

    task automatic check(input string name, input longint act, input longint expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    function automatic void model_reset();
        m_acc = 0; m_ctrl = 0; m_state = 0; m_acq = 0;
        m_strobe = 0; m_mu = 0; m_sat = 0; m_slip = 0; m_gap = 0;
    endfunction

    function automatic void model_clear();
        m_acc = 0; m_acq = 0; m_strobe = 0; m_mu = 0; m_sat = 0; m_gap = 0;
    endfunction

    // One sample-clock of the timing loop, from the written rules.
    function automatic void model_step(bit rn, bit en, bit dv, bit cv, int ctrl);
        longint raw, step;
        if (!rn) begin
            model_reset();
            return;
        end
        if (!en) begin
            m_state = 0;
            model_clear();
        end else if (m_state == 0) begin
            m_state = 1;
            model_clear();
        end else if (dv) begin
            raw   = W_NOM + ((m_state == 2) ? m_ctrl * (64'd1 << CTRL_SHIFT) : 0);
            step  = (raw > SMAX) ? SMAX : ((raw < SMIN) ? SMIN : raw);
            m_sat = (step != raw) ? 1 : 0;
            if (m_acc >= step) begin
                m_acc    = m_acc - step;
                m_strobe = 0;
                m_gap++;
            end else begin
                m_mu     = int'(((m_acc * SPS) % MODV) >> (NCO_W - MU_W));
                m_acc    = m_acc - step + MODV;
                m_strobe = 1;
`ifdef TIMING_NCO_SLIP_CNT_EN
                if (m_state == 2 && (m_gap + 1) != SPS && m_slip < 65535)
                    m_slip++;
`endif
                m_gap = 0;
                if (m_state == 1) begin
                    m_acq++;
                    if (m_acq == ACQ_SYMS)
                        m_state = 2;
                end
            end
        end else begin
            m_strobe = 0;
        end
        if (cv)
            m_ctrl = ctrl;
    endfunction

    task automatic push_exp();
        exq.push_back('{m_strobe, m_mu, m_sat, m_state, m_slip});
    endtask

    task automatic drive(input bit rn, input bit en, input bit dv, input bit cv, input int ctrl);
        @(negedge clk);
        reset_n     = rn;
        enable_i    = en;
        din_valid_i = dv;
        ctrl_val_i  = cv;
        ctrl_i      = WERR'(ctrl);
        model_step(rn, en, dv, cv, ctrl);
        push_exp();
    endtask

    task automatic async_reset_mid();
        @(negedge clk);
        enable_i    = 1'b1;
        din_valid_i = 1'b1;
        ctrl_val_i  = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_strobe", strobe_o, 0);
        check("async_mu", mu_o, 0);
        check("async_sat", sat_o, 0);
        check("async_state", state_o, 0);
        check("async_slip", slip_cnt_o, 0);
        push_exp();
    endtask

    // Monitor: pops one expectation per clock and compares against the DUT.
    initial begin
        exp_t e;
        int   prev_strobe;
        prev_strobe = 0;
        forever begin
            @(posedge clk);
            #2;
            if (exq.size() > 0) begin
                e = exq.pop_front();
                check("strobe", strobe_o, e.strobe);
                check("mu", mu_o, e.mu);
                check("sat", sat_o, e.sat);
                check("state", state_o, e.state);
                check("slip_cnt", slip_cnt_o, e.slip);
                check("no_double_strobe", int'(strobe_o) & prev_strobe, 0);
            end
            prev_strobe = int'(strobe_o);
        end
    end

    initial begin
        model_reset();
        repeat (3) drive(0, 0, 0, 0, 0);

        // nominal: strobe on first valid then every 4
        for (int i = 0; i < 90; i++) drive(1, 1, 1, 0, 0);

        // ctrl loaded during ACQ is held back until TRACK
        drive(1, 0, 1, 0, 0);
        drive(1, 1, 1, 1, 1000);
        for (int i = 0; i < 90; i++) drive(1, 1, 1, 0, 0);

        // saturation at both extremes
        drive(1, 1, 1, 1, 131071);
        for (int i = 0; i < 20; i++) drive(1, 1, 1, 0, 0);
        drive(1, 1, 1, 1, -131072);
        for (int i = 0; i < 20; i++) drive(1, 1, 1, 0, 0);

        // gapped input, ctrl back to zero
        for (int i = 0; i < 72; i++) drive(1, 1, (i % 3) == 0, i == 0, 0);

        // disable two clocks after a strobe, then re-enable
        for (int k = 0; k < 20 && m_strobe == 0; k++) drive(1, 1, 1, 0, 0);
        drive(1, 1, 1, 0, 0);
        drive(1, 0, 1, 0, 0);
        for (int i = 0; i < 80; i++) drive(1, 1, 1, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel, cv_val;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       cv_val = int'($urandom_range(0, 262143)) - 131072;
                1:       cv_val = int'($urandom_range(0, 20000)) - 10000;
                2:       cv_val = ($urandom_range(0, 1) == 1) ? 131071 : -131072;
                default: cv_val = int'($urandom_range(0, 32767)) - 16384;
            endcase
            drive(1, ($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0), cv_val);
        end

        // reach TRACK, then async reset off the clock edge
        drive(1, 0, 0, 1, 0);
        for (int i = 0; i < 80; i++) drive(1, 1, 1, 0, 0);
        async_reset_mid();
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0);

        // minimum step: period alternates 4/5, exercising slips
        drive(1, 1, 1, 1, -131072);
        for (int i = 0; i < 200; i++) drive(1, 1, 1, 0, 0);

        repeat (3) @(negedge clk);
        check("queue_drained", exq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
